// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv_pkg                                                  |
// | Brief    : Shared types and constants for the conv frame loader      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package conv_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEN       = 3'd1,
    PAYLOAD   = 3'd2,
    CHECK     = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CHKSUM  = 2'd2;
  localparam logic [1:0] ERR_LEN     = 2'd3;

  // Default frame start marker
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Largest payload for the default 6-bit address space
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int MAX_LEN            = 2 ** DEFAULT_ADDR_WIDTH;

  // Largest payload for an arbitrary address width
  function automatic int unsigned max_len(input int addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frame_timeout_counter                                     |
// | Brief    : Idle-cycle watchdog; pulses expired when TIMEOUT_CYCLES   |
// |            cycles pass without a clear while enabled                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A clear in the expiry cycle suppresses the pulse: an arriving byte wins.
  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

  // Next count: zero when cleared, disabled or expiring, else increment
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || !enable_i || expired_o) begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv_frame_loader                                         |
// | Brief    : Parses SYNC/LEN/payload/XOR frames from the UART byte     |
// |            stream, writes the payload into conv core memory and      |
// |            starts the core on a good checksum                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module conv_frame_loader
  import conv_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 6,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = DATA_WIDTH'(SYNC_BYTE_DEFAULT),
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  start_conv,
  input  logic                  conv_done,
  output logic                  busy,
  output logic                  frame_err,
  output logic [1:0]            err_code
);

  // Index/length carry one extra bit so a full-size payload count does not wrap
  localparam int          LW        = ADDR_WIDTH + 1;
  localparam int unsigned LEN_LIMIT = max_len(ADDR_WIDTH);

  state_e                state_q;
  logic [LW-1:0]         idx_q;
  logic [LW-1:0]         len_q;
  logic [DATA_WIDTH-1:0] chk_q;
  logic                  mem_wr_en_q;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_q;
  logic [DATA_WIDTH-1:0] mem_wr_data_q;
  logic                  start_conv_q;
  logic                  busy_q;
  logic                  frame_err_q;
  logic [1:0]            err_code_q;

  logic                  w_tmo_enable;
  logic                  w_expired;
  logic                  w_len_ok;
  logic [LW-1:0]         w_idx_next;

  assign w_tmo_enable = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
  assign w_len_ok     = (rx_data != '0) && (32'(rx_data) <= LEN_LIMIT);
  assign w_idx_next   = idx_q + LW'(1);

  frame_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (rx_valid),
    .enable_i  (w_tmo_enable),
    .expired_o (w_expired)
  );

  // Frame parser FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      chk_q         <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      start_conv_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      mem_wr_en_q  <= 1'b0;
      start_conv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q     <= LEN;
            busy_q      <= 1'b1;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
          end
        end
        LEN: begin
          if (rx_valid) begin
            if (w_len_ok) begin
              state_q <= PAYLOAD;
              chk_q   <= rx_data;
              idx_q   <= '0;
              len_q   <= LW'(rx_data);
            end else begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
            end
          end else if (w_expired) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
          end
        end
        PAYLOAD: begin
          if (rx_valid) begin
            mem_wr_en_q   <= 1'b1;
            mem_wr_addr_q <= idx_q[ADDR_WIDTH-1:0];
            mem_wr_data_q <= rx_data;
            chk_q         <= chk_q ^ rx_data;
            idx_q         <= w_idx_next;
            if (w_idx_next == len_q) begin
              state_q <= CHECK;
            end
          end else if (w_expired) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
          end
        end
        CHECK: begin
          if (rx_valid) begin
            if (rx_data == chk_q) begin
              state_q      <= WAIT_DONE;
              start_conv_q <= 1'b1;
            end else begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHKSUM;
            end
          end else if (w_expired) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
          end
        end
        WAIT_DONE: begin
          // Incoming bytes are dropped while the core runs
          if (conv_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign start_conv  = start_conv_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_conv_frame_loader                                      |
// | Brief    : Directed self-checking bench for conv_frame_loader        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_conv_frame_loader;

  localparam int TMO = 50;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       mem_wr_en;
  logic [5:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       start_conv;
  logic       conv_done;
  logic       busy;
  logic       frame_err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int start_count = 0;

  logic [7:0] pay [11] = '{8'h03, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02,
                           8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

  conv_frame_loader #(
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (6),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .start_conv  (start_conv),
    .conv_done   (conv_done),
    .busy        (busy),
    .frame_err   (frame_err),
    .err_code    (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event counters and write/start exclusivity, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) wr_count++;
    if (start_conv === 1'b1) start_count++;
    if (!reset) check("wr_start_excl", {31'd0, mem_wr_en & start_conv}, 32'd0);
  end

  // Drive one byte from a negedge; check the response one cycle later and
  // that strobes last exactly one cycle. Returns two negedges later.
  task automatic send(input logic [7:0] b, input logic exp_wr, input logic [5:0] exp_addr,
                      input logic exp_start, input string tag);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check({tag, "_wr"}, mem_wr_en, exp_wr);
    if (exp_wr) begin
      check({tag, "_addr"}, mem_wr_addr, exp_addr);
      check({tag, "_data"}, mem_wr_data, b);
    end
    check({tag, "_start"}, start_conv, exp_start);
    @(negedge clk);
    check({tag, "_wr_1cyc"}, mem_wr_en, 1'b0);
    check({tag, "_start_1cyc"}, start_conv, 1'b0);
    @(negedge clk);
  endtask

  // Header of the 11-byte nominal frame plus payload writes
  task automatic send_nominal_body(input string tag);
    send(8'hA5, 1'b0, 6'd0, 1'b0, {tag, "_sync"});
    check({tag, "_busy_len"}, busy, 1'b1);
    send(8'h0B, 1'b0, 6'd0, 1'b0, {tag, "_len"});
    for (int i = 0; i < 11; i++) begin
      send(pay[i], 1'b1, 6'(i), 1'b0, $sformatf("%s_p%0d", tag, i));
    end
  endtask

  task automatic pulse_done(input string tag);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    check({tag, "_busy_after_done"}, busy, 1'b0);
    check({tag, "_err_after_done"}, err_code, 2'd0);
  endtask

  int wr_snap;
  int st_snap;

  initial begin
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    conv_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_addr", mem_wr_addr, 6'd0);
    check("rst_data", mem_wr_data, 8'd0);
    check("rst_start", start_conv, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ecode", err_code, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    // Garbage in IDLE is ignored
    send(8'h00, 1'b0, 6'd0, 1'b0, "garb00");
    send(8'hFF, 1'b0, 6'd0, 1'b0, "garbFF");
    send(8'h5A, 1'b0, 6'd0, 1'b0, "garb5A");
    check("garb_busy", busy, 1'b0);
    check("garb_ferr", frame_err, 1'b0);

    // Nominal frame, with a byte dropped during WAIT_DONE
    st_snap = start_count;
    send_nominal_body("nom");
    send(8'h0D, 1'b0, 6'd0, 1'b1, "nom_chk");
    check("nom_busy_wait", busy, 1'b1);
    send(8'h22, 1'b0, 6'd0, 1'b0, "nom_waitbyte");
    check("nom_busy_wait2", busy, 1'b1);
    check("nom_ferr", frame_err, 1'b0);
    pulse_done("nom");
    check("nom_start_cnt", start_count - st_snap, 1);

    // Bad checksum
    st_snap = start_count;
    send_nominal_body("bad");
    send(8'h0E, 1'b0, 6'd0, 1'b0, "bad_chk");
    check("bad_ferr", frame_err, 1'b1);
    check("bad_ecode", err_code, 2'd2);
    check("bad_busy", busy, 1'b0);
    check("bad_start_cnt", start_count - st_snap, 0);

    // Zero and oversize lengths
    wr_snap = wr_count;
    send(8'hA5, 1'b0, 6'd0, 1'b0, "len0_sync");
    check("len0_clr_ferr", frame_err, 1'b0);
    send(8'h00, 1'b0, 6'd0, 1'b0, "len0_len");
    check("len0_ferr", frame_err, 1'b1);
    check("len0_ecode", err_code, 2'd3);
    check("len0_busy", busy, 1'b0);
    send(8'hA5, 1'b0, 6'd0, 1'b0, "len41_sync");
    send(8'h41, 1'b0, 6'd0, 1'b0, "len41_len");
    check("len41_ferr", frame_err, 1'b1);
    check("len41_ecode", err_code, 2'd3);
    check("len41_busy", busy, 1'b0);
    check("len_err_writes", wr_count - wr_snap, 0);
    send_nominal_body("rec");
    check("rec_ferr_cleared", frame_err, 1'b0);
    check("rec_ecode_cleared", err_code, 2'd0);
    send(8'h0D, 1'b0, 6'd0, 1'b1, "rec_chk");
    pulse_done("rec");

    // Timeout: 50 idle cycles after the last byte
    wr_snap = wr_count;
    send(8'hA5, 1'b0, 6'd0, 1'b0, "tmo_sync");
    send(8'h03, 1'b0, 6'd0, 1'b0, "tmo_len");
    send(8'h11, 1'b1, 6'd0, 1'b0, "tmo_p0");
    send(8'h22, 1'b1, 6'd1, 1'b0, "tmo_p1");
    repeat (TMO - 3) @(negedge clk);
    check("tmo_pre_ecode", err_code, 2'd0);
    check("tmo_pre_busy", busy, 1'b1);
    @(negedge clk);
    check("tmo_ecode", err_code, 2'd1);
    check("tmo_ferr", frame_err, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_writes", wr_count - wr_snap, 2);

    // A byte landing on the timeout cycle keeps the frame alive
    send(8'hA5, 1'b0, 6'd0, 1'b0, "edge_sync");
    send(8'h03, 1'b0, 6'd0, 1'b0, "edge_len");
    send(8'h11, 1'b1, 6'd0, 1'b0, "edge_p0");
    send(8'h22, 1'b1, 6'd1, 1'b0, "edge_p1");
    repeat (TMO - 3) @(negedge clk);
    send(8'h33, 1'b1, 6'd2, 1'b0, "edge_p2");
    check("edge_ecode", err_code, 2'd0);
    check("edge_busy", busy, 1'b1);
    send(8'h03, 1'b0, 6'd0, 1'b1, "edge_chk");
    pulse_done("edge");

    // Asynchronous reset mid-payload
    st_snap = start_count;
    send(8'hA5, 1'b0, 6'd0, 1'b0, "arst_sync");
    send(8'h0B, 1'b0, 6'd0, 1'b0, "arst_len");
    for (int i = 0; i < 3; i++) begin
      send(pay[i], 1'b1, 6'(i), 1'b0, $sformatf("arst_p%0d", i));
    end
    rx_data  = 8'h04;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("arst_pre_wr", mem_wr_en, 1'b1);
    reset = 1'b1;
    #1;
    check("arst_wr_en", mem_wr_en, 1'b0);
    check("arst_addr", mem_wr_addr, 6'd0);
    check("arst_data", mem_wr_data, 8'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_ferr", frame_err, 1'b0);
    check("arst_ecode", err_code, 2'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(8'h01, 1'b0, 6'd0, 1'b0, "arst_tail0");
    send(8'h0D, 1'b0, 6'd0, 1'b0, "arst_tail1");
    check("arst_no_start", start_count - st_snap, 0);
    send_nominal_body("post");
    send(8'h0D, 1'b0, 6'd0, 1'b1, "post_chk");
    pulse_done("post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
